// File: rtl/bram_arb_pkg.sv
// Shared constants for the BRAM arbiter: geometry of the BRAM and the
// identifiers of the two requesters that share it.
package bram_arb_pkg;

  localparam int ADDR_WIDTH = 13;
  localparam int DATA_WIDTH = 32;
  localparam int DEPTH      = 8192;

  localparam logic REQ_WALK = 1'b0;
  localparam logic REQ_HOST = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. A lone requester always wins; under
// contention the requester that was not granted last wins. The
// last-grant pointer only moves when the caller reports a transfer.
module rr_arb2
  import bram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last_grant;

  // Pick the winner for this cycle from the requests and the pointer
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_grant == REQ_HOST) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Remember who won the most recent transfer; starts at host so walk wins first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= REQ_HOST;
    end else if (advance) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/bram_arbiter.sv
// Shares one single-port BRAM between the random-walk engine (requester 0)
// and the host loader (requester 1). One command is accepted per cycle,
// registered into stage 1 which drives the BRAM, then tracked in stage 2
// while the BRAM's registered read data comes back to the issuing requester.
module bram_arbiter #(
  parameter int ADDR_WIDTH = bram_arb_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = bram_arb_pkg::DATA_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,

  input  logic                  i_req0_valid,
  output logic                  o_req0_ready,
  input  logic                  i_req0_we,
  input  logic [ADDR_WIDTH-1:0] i_req0_addr,
  input  logic [DATA_WIDTH-1:0] i_req0_wdata,
  output logic                  o_rsp0_valid,
  output logic [DATA_WIDTH-1:0] o_rsp0_rdata,

  input  logic                  i_req1_valid,
  output logic                  o_req1_ready,
  input  logic                  i_req1_we,
  input  logic [ADDR_WIDTH-1:0] i_req1_addr,
  input  logic [DATA_WIDTH-1:0] i_req1_wdata,
  output logic                  o_rsp1_valid,
  output logic [DATA_WIDTH-1:0] o_rsp1_rdata,

  output logic [ADDR_WIDTH-1:0] o_bram_addr,
  output logic                  o_bram_write,
  output logic [DATA_WIDTH-1:0] o_bram_wdata,
  input  logic [DATA_WIDTH-1:0] i_bram_rdata,

  output logic                  o_busy
);

  import bram_arb_pkg::*;

  logic [1:0]            req_vec;
  logic [1:0]            grant;
  logic [1:0]            ready;
  logic                  accept;
  logic                  sel_host;
  logic                  acc_we;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0] acc_wdata;

  logic                  s1_valid;
  logic                  s1_read;
  logic                  s1_id;
  logic                  s2_valid;
  logic                  s2_read;
  logic                  s2_id;

  assign req_vec = {i_req1_valid, i_req0_valid};

  rr_arb2 u_arb (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .req     (req_vec),
    .advance (accept),
    .grant   (grant)
  );

  // Ready is held low while reset is asserted, even if requesters are valid
  assign ready        = grant & {2{i_rst_n}};
  assign o_req0_ready = ready[0];
  assign o_req1_ready = ready[1];
  assign accept       = |(req_vec & ready);

  // Select the winning requester's command fields
  assign sel_host  = ready[1];
  assign acc_we    = sel_host ? i_req1_we    : i_req0_we;
  assign acc_addr  = sel_host ? i_req1_addr  : i_req0_addr;
  assign acc_wdata = sel_host ? i_req1_wdata : i_req0_wdata;

  // Stage 1: capture the accepted command; its address/data registers drive the BRAM directly
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid     <= 1'b0;
      s1_read      <= 1'b0;
      s1_id        <= REQ_WALK;
      o_bram_write <= 1'b0;
      o_bram_addr  <= '0;
      o_bram_wdata <= '0;
    end else begin
      s1_valid     <= accept;
      s1_read      <= accept & ~acc_we;
      o_bram_write <= accept & acc_we;
      if (accept) begin
        s1_id        <= sel_host;
        o_bram_addr  <= acc_addr;
        o_bram_wdata <= acc_wdata;
      end
    end
  end

  // Stage 2: the BRAM has sampled the address; its read data is valid this cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s2_valid <= 1'b0;
      s2_read  <= 1'b0;
      s2_id    <= REQ_WALK;
    end else begin
      s2_valid <= s1_valid;
      s2_read  <= s1_read;
      s2_id    <= s1_id;
    end
  end

  assign o_rsp0_valid = s2_read & (s2_id == REQ_WALK);
  assign o_rsp1_valid = s2_read & (s2_id == REQ_HOST);
  assign o_rsp0_rdata = i_bram_rdata;
  assign o_rsp1_rdata = i_bram_rdata;
  assign o_busy       = s1_valid | s2_valid;

endmodule

// File: tb/tb_bram_arbiter.sv
// Testbench for bram_arbiter: a write-first registered BRAM model plus a
// transaction-level reference (round-robin rule, ordered memory, two-cycle
// read latency) that predicts ready, response and BRAM-port behaviour.
module tb_bram_arbiter;

  import bram_arb_pkg::*;

  localparam int AW = ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid, req0_ready, req0_we;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata;
  logic          rsp0_valid;
  logic [DW-1:0] rsp0_rdata;
  logic          req1_valid, req1_ready, req1_we;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata;
  logic          rsp1_valid;
  logic [DW-1:0] rsp1_rdata;
  logic [AW-1:0] bram_addr;
  logic          bram_write;
  logic [DW-1:0] bram_wdata;
  logic [DW-1:0] bram_rdata;
  logic          busy;

  always #5 clk = ~clk;

  bram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req0_valid (req0_valid),
    .o_req0_ready (req0_ready),
    .i_req0_we    (req0_we),
    .i_req0_addr  (req0_addr),
    .i_req0_wdata (req0_wdata),
    .o_rsp0_valid (rsp0_valid),
    .o_rsp0_rdata (rsp0_rdata),
    .i_req1_valid (req1_valid),
    .o_req1_ready (req1_ready),
    .i_req1_we    (req1_we),
    .i_req1_addr  (req1_addr),
    .i_req1_wdata (req1_wdata),
    .o_rsp1_valid (rsp1_valid),
    .o_rsp1_rdata (rsp1_rdata),
    .o_bram_addr  (bram_addr),
    .o_bram_write (bram_write),
    .o_bram_wdata (bram_wdata),
    .i_bram_rdata (bram_rdata),
    .o_busy       (busy)
  );

  // Single-port BRAM, write-first, registered output
  logic [DW-1:0] bram_mem [DEPTH];
  always @(posedge clk) begin
    if (bram_write) begin
      bram_mem[bram_addr] <= bram_wdata;
      bram_rdata          <= bram_wdata;
    end else begin
      bram_rdata <= bram_mem[bram_addr];
    end
  end

  // Reference model state
  typedef struct packed {
    logic          valid;
    logic          is_read;
    logic          id;
    logic [DW-1:0] data;
  } slot_t;

  logic [DW-1:0] ref_mem [DEPTH];
  slot_t         slot_now, slot_next;
  int            last_grant;
  logic [AW-1:0] last_addr;

  logic exp_ready0, exp_ready1, exp_rsp0, exp_rsp1, exp_busy, exp_bram_write;
  logic [DW-1:0] exp_rsp_data;
  logic [AW-1:0] exp_bram_addr;
  logic obs_ready0, obs_ready1, obs_rsp0, obs_rsp1, obs_busy, obs_bram_write;
  logic [DW-1:0] obs_rsp0_data, obs_rsp1_data;
  logic [AW-1:0] obs_bram_addr;

  int tests_run    = 0;
  int tests_failed = 0;
  int exp_rsp_count, obs_rsp_count;

  task automatic model_reset();
    last_grant = 1;
    slot_now   = '0;
    slot_next  = '0;
    last_addr  = '0;
  endtask

  // Drive one cycle of requests, predict and snapshot outputs, advance the model
  task automatic drive_cycle(input logic v0, input logic we0, input logic [AW-1:0] a0,
                             input logic [DW-1:0] d0, input logic v1, input logic we1,
                             input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    int            g;
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    @(negedge clk);
    req0_valid = v0; req0_we = we0; req0_addr = a0; req0_wdata = d0;
    req1_valid = v1; req1_we = we1; req1_addr = a1; req1_wdata = d1;
    #1;
    g = -1;
    if (v0 && !v1)      g = 0;
    else if (v1 && !v0) g = 1;
    else if (v0 && v1)  g = (last_grant == 0) ? 1 : 0;
    exp_ready0     = (g == 0);
    exp_ready1     = (g == 1);
    exp_rsp0       = slot_now.valid && slot_now.is_read && (slot_now.id == 1'b0);
    exp_rsp1       = slot_now.valid && slot_now.is_read && (slot_now.id == 1'b1);
    exp_rsp_data   = slot_now.data;
    exp_busy       = slot_now.valid || slot_next.valid;
    exp_bram_write = slot_next.valid && !slot_next.is_read;
    exp_bram_addr  = last_addr;
    obs_ready0     = req0_ready;
    obs_ready1     = req1_ready;
    obs_rsp0       = rsp0_valid;
    obs_rsp1       = rsp1_valid;
    obs_rsp0_data  = rsp0_rdata;
    obs_rsp1_data  = rsp1_rdata;
    obs_busy       = busy;
    obs_bram_write = bram_write;
    obs_bram_addr  = bram_addr;
    if (exp_rsp0 || exp_rsp1) exp_rsp_count++;
    if (obs_rsp0 === 1'b1 || obs_rsp1 === 1'b1) obs_rsp_count++;
    slot_now  = slot_next;
    slot_next = '0;
    if (g >= 0) begin
      we = (g == 1) ? we1 : we0;
      a  = (g == 1) ? a1  : a0;
      d  = (g == 1) ? d1  : d0;
      if (we) ref_mem[a] = d;
      slot_next.valid   = 1'b1;
      slot_next.is_read = !we;
      slot_next.id      = (g == 1);
      slot_next.data    = ref_mem[a];
      last_grant = g;
      last_addr  = a;
    end
    @(posedge clk);
  endtask

  task automatic idle_cycle();
    drive_cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 13'h5; req0_wdata = '0;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 13'h6; req1_wdata = '0;
    #3 rst_n = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk); @(negedge clk);
    tests_run++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL reset_ready: got %b%b want 00", req0_ready, req1_ready);
    end
    tests_run++;
    if ({rsp0_valid, rsp1_valid, busy} !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL reset_rsp_busy: got %b%b%b want 000", rsp0_valid, rsp1_valid, busy);
    end
    tests_run++;
    if (bram_write !== 1'b0 || bram_addr !== '0 || bram_wdata !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_bram: got w=%b a=%h d=%h want 0/0/0", bram_write, bram_addr, bram_wdata);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic test_first_grant();
    drive_cycle(1'b1, 1'b0, 13'h5, '0, 1'b1, 1'b0, 13'h6, '0);
    tests_run++;
    if (obs_ready0 !== 1'b1 || obs_ready1 !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL first_grant: got %b%b want 10", obs_ready0, obs_ready1);
    end
    idle_cycle(); idle_cycle();
  endtask

  task automatic test_load_and_read();
    for (int i = 0; i < 16; i++) begin
      drive_cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, AW'(i), DW'(32'h100 + i));
      tests_run++;
      if (obs_ready1 !== 1'b1 || obs_ready0 !== 1'b0 || obs_bram_write !== exp_bram_write) begin
        tests_failed++;
        $display("[TB] FAIL load_write[%0d]: got rdy=%b%b w=%b want 01 w=%b", i, obs_ready0, obs_ready1, obs_bram_write, exp_bram_write);
      end
    end
    for (int i = 0; i < 18; i++) begin
      if (i < 16) drive_cycle(1'b1, 1'b0, AW'(i), '0, 1'b0, 1'b0, '0, '0);
      else        idle_cycle();
      tests_run++;
      if (obs_rsp0 !== exp_rsp0 || obs_rsp1 !== 1'b0 || (exp_rsp0 && obs_rsp0_data !== exp_rsp_data)) begin
        tests_failed++;
        $display("[TB] FAIL load_read[%0d]: got v=%b%b d=%h want v=%b0 d=%h", i, obs_rsp0, obs_rsp1, obs_rsp0_data, exp_rsp0, exp_rsp_data);
      end
    end
  endtask

  task automatic test_alternate();
    logic [AW-1:0] a;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      a = AW'($urandom_range(0, 15));
      if (i < 8) drive_cycle(1'b1, 1'b0, a, '0, 1'b1, 1'b0, a, '0);
      else       idle_cycle();
      if (i < 8) begin
        tests_run++;
        if (obs_ready0 !== (i % 2 == 0) || obs_ready1 !== (i % 2 == 1)) begin
          tests_failed++;
          $display("[TB] FAIL alternate[%0d]: got %b%b want %b%b", i, obs_ready0, obs_ready1, (i % 2 == 0), (i % 2 == 1));
        end
      end
      tests_run++;
      if (obs_rsp0 !== exp_rsp0 || obs_rsp1 !== exp_rsp1) begin
        tests_failed++;
        $display("[TB] FAIL alternate_rsp[%0d]: got %b%b want %b%b", i, obs_rsp0, obs_rsp1, exp_rsp0, exp_rsp1);
      end
    end
  endtask

  task automatic test_solo();
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b1, 1'b0, AW'(i), '0, 1'b0, 1'b0, '0, '0);
      tests_run++;
      if (obs_ready0 !== 1'b1 || (i >= 2 && obs_busy !== 1'b1)) begin
        tests_failed++;
        $display("[TB] FAIL solo[%0d]: got rdy0=%b busy=%b want 1/1", i, obs_ready0, obs_busy);
      end
    end
    drive_cycle(1'b1, 1'b0, 13'h7, '0, 1'b1, 1'b0, 13'h8, '0);
    tests_run++;
    if (obs_ready0 !== 1'b0 || obs_ready1 !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL solo_contend: got %b%b want 01", obs_ready0, obs_ready1);
    end
    idle_cycle(); idle_cycle();
  endtask

  task automatic test_boundary();
    drive_cycle(1'b1, 1'b1, 13'h1FFF, 32'hDEADBEEF, 1'b0, 1'b0, '0, '0);
    drive_cycle(1'b1, 1'b0, 13'h1FFF, '0, 1'b0, 1'b0, '0, '0);
    tests_run++;
    if (obs_bram_write !== 1'b1 || obs_bram_addr !== 13'h1FFF) begin
      tests_failed++;
      $display("[TB] FAIL boundary_write: got w=%b a=%h want 1/1fff", obs_bram_write, obs_bram_addr);
    end
    idle_cycle();
    tests_run++;
    if (obs_bram_write !== 1'b0 || obs_bram_addr !== 13'h1FFF) begin
      tests_failed++;
      $display("[TB] FAIL boundary_read_addr: got w=%b a=%h want 0/1fff", obs_bram_write, obs_bram_addr);
    end
    idle_cycle();
    tests_run++;
    if (obs_rsp0 !== 1'b1 || obs_rsp0_data !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("[TB] FAIL boundary_rsp: got v=%b d=%h want 1/deadbeef", obs_rsp0, obs_rsp0_data);
    end
    idle_cycle();
    tests_run++;
    if (obs_busy !== 1'b0 || obs_rsp0 !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL boundary_idle: got busy=%b v=%b want 0/0", obs_busy, obs_rsp0);
    end
  endtask

  task automatic test_reset_mid();
    drive_cycle(1'b1, 1'b0, 13'h3, '0, 1'b1, 1'b0, 13'h4, '0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    tests_run++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, bram_write} !== 6'b0 ||
        bram_addr !== '0 || bram_wdata !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_outputs: got rdy=%b%b rsp=%b%b busy=%b w=%b a=%h d=%h want all 0",
               req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, bram_write, bram_addr, bram_wdata);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle_cycle();
      tests_run++;
      if (obs_rsp0 !== 1'b0 || obs_rsp1 !== 1'b0 || obs_busy !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL reset_mid_after[%0d]: got rsp=%b%b busy=%b want 000", i, obs_rsp0, obs_rsp1, obs_busy);
      end
    end
  endtask

  task automatic test_random();
    logic          v0, v1, w0, w1;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    int            errs;
    errs = 0;
    exp_rsp_count = 0;
    obs_rsp_count = 0;
    for (int i = 0; i < 10002; i++) begin
      v0 = (i < 10000) && ($urandom_range(0, 9) < 7);
      v1 = (i < 10000) && ($urandom_range(0, 9) < 5);
      w0 = $urandom_range(0, 2) == 0;
      w1 = $urandom_range(0, 1) == 0;
      a0 = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 31));
      d0 = $urandom;
      d1 = $urandom;
      drive_cycle(v0, w0, a0, d0, v1, w1, a1, d1);
      tests_run++;
      if (obs_ready0 !== exp_ready0 || obs_ready1 !== exp_ready1 ||
          obs_rsp0 !== exp_rsp0 || obs_rsp1 !== exp_rsp1 ||
          (exp_rsp0 && obs_rsp0_data !== exp_rsp_data) ||
          (exp_rsp1 && obs_rsp1_data !== exp_rsp_data) ||
          obs_busy !== exp_busy || obs_bram_write !== exp_bram_write ||
          obs_bram_addr !== exp_bram_addr) begin
        tests_failed++;
        errs++;
        if (errs <= 10)
          $display("[TB] FAIL random[%0d]: got rdy=%b%b rsp=%b%b d0=%h d1=%h busy=%b w=%b a=%h want rdy=%b%b rsp=%b%b d=%h busy=%b w=%b a=%h",
                   i, obs_ready0, obs_ready1, obs_rsp0, obs_rsp1, obs_rsp0_data, obs_rsp1_data,
                   obs_busy, obs_bram_write, obs_bram_addr, exp_ready0, exp_ready1,
                   exp_rsp0, exp_rsp1, exp_rsp_data, exp_busy, exp_bram_write, exp_bram_addr);
      end
    end
    tests_run++;
    if (obs_rsp_count !== exp_rsp_count) begin
      tests_failed++;
      $display("[TB] FAIL random_rsp_count: got %0d want %0d", obs_rsp_count, exp_rsp_count);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i]  = '0;
      bram_mem[i] = '0;
    end
    exp_rsp_count = 0;
    obs_rsp_count = 0;
    test_reset();
    test_first_grant();
    test_load_and_read();
    test_alternate();
    test_solo();
    test_boundary();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
